// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: data width and launch FSM encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    START = 2'b10,
    WAIT  = 2'b11
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_checker.sv
// Structural invariants of the transmit buffer, kept apart from the datapath.
module uart_tx_fifo_checker #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            reset,
  input logic            full,
  input logic            empty,
  input logic [ADDR_W:0] count,
  input logic            overflow,
  input logic            busy,
  input logic            tx_transmission
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  a_full_flag: assert property (@(posedge clk) disable iff (reset) full == (count == DEPTH_CNT));
  a_empty_flag: assert property (@(posedge clk) disable iff (reset) empty == (count == '0));
  a_count_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_CNT);
  a_strobe_single: assert property (@(posedge clk) disable iff (reset) tx_transmission |=> !tx_transmission);
  a_strobe_busy: assert property (@(posedge clk) disable iff (reset) tx_transmission |-> busy);
  a_overflow_sticky: assert property (@(posedge clk) disable iff (reset) overflow |=> overflow);

endmodule

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte FIFO with registered occupancy, full/empty flags and a sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W - 1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [ADDR_W:0]   count_next;

  assign rd_data = mem[rd_ptr];

  // Accept/pop qualification uses the registered flags, so a write while full is refused even if a pop lands that cycle.
  always_comb begin
    do_wr      = wr_en & ~full;
    do_rd      = rd_en & ~empty;
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + CNT_ONE;
    end else if (do_rd && !do_wr) begin
      count_next = count - CNT_ONE;
    end else begin
      count_next = count;
    end
  end

  // Storage array carries no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; flags are registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer ahead of the UART transmitter: queues host writes and launches one byte per tx_done handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_transmission,
  input  logic              tx_done
);

  tx_state_e         state;
  logic              tx_done_q;
  logic              done_rise;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign done_rise = tx_done & ~tx_done_q;
  assign pop       = (state == LOAD) & ~empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Launch FSM; tx_done is edge-detected so a held level completes only one frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tx_data         <= '0;
      tx_transmission <= 1'b0;
      busy            <= 1'b0;
      tx_done_q       <= 1'b0;
    end else begin
      tx_done_q       <= tx_done;
      tx_transmission <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (!empty) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!empty) begin
            tx_data         <= head;
            tx_transmission <= 1'b1;
            busy            <= 1'b1;
            state           <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  uart_tx_fifo_checker #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_chk (
    .clk             (clk),
    .reset           (reset),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .busy            (busy),
    .tx_transmission (tx_transmission)
  );

endmodule
